// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module ex_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      done_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN-1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   div_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              rem_op_q;
    logic              special_q;
    logic [XLEN-1:0]   spec_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        done_rd_q;

    // Request decode
    logic              is_signed;
    logic              div_zero;
    logic              ovf;
    logic              special;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [XLEN-1:0]   spec_val;

    always_comb begin
        is_signed = ~op[0];
        div_zero  = (rs2_data == '0);
        ovf       = is_signed && (rs1_data == MIN_NEG) && (rs2_data == '1);
        special   = div_zero | ovf;
        a_abs     = (is_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        b_abs     = (is_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
        if (op[1])
            spec_val = div_zero ? rs1_data : '0;
        else
            spec_val = div_zero ? '1 : MIN_NEG;
    end

    // Shift-subtract step; the extra top bit of the working remainder keeps the carry
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic              take;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;

    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, div_q};
        take   = ~diff[XLEN];
        rem_nx = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], take};
    end

    // Sign fix-up; sign bits are recorded as zero for unsigned ops
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   fin_val;

    always_comb begin
        q_fix   = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        r_fix   = sign_a_q ? -rem_q : rem_q;
        fin_val = special_q ? spec_q : (rem_op_q ? r_fix : q_fix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nx = special ? S_FIN : S_CALC;
                S_CALC:  if (cnt == LAST) state_nx = S_FIN;
                S_FIN:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            rem_op_q  <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            done_rd_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        cnt       <= '0;
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        div_q     <= b_abs;
                        sign_a_q  <= is_signed & rs1_data[XLEN-1];
                        sign_b_q  <= is_signed & rs2_data[XLEN-1];
                        rem_op_q  <= op[1];
                        special_q <= special;
                        spec_q    <= spec_val;
                        rd_q      <= rd_addr;
                    end
                end
                S_CALC: begin
                    quo_q <= quo_nx;
                    rem_q <= rem_nx;
                    cnt   <= cnt + CNT_W'(1);
                end
                S_FIN: begin
                    // done is already visible this cycle, so commit even under flush
                    result_q  <= fin_val;
                    done_rd_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_FIN);
        result  = (state == S_FIN) ? fin_val : result_q;
        done_rd = (state == S_FIN) ? rd_q : done_rd_q;
    end

endmodule
